set_job_dispatcher: RTL and testbench
=====================================

Name: set_job_dispatcher

Overview:
- Upstream feeder for the SET circle-intersection counter.
- Buffers jobs from the host (central coordinates, radii, tag) in a small FIFO and launches each job into SET through its en/busy/valid handshake.
- Captures SET's 4-bit candidate count and returns it on a valid/ready result stream together with the job's tag.
- Lets the host queue jobs without tracking SET's Prep/DataIn/Cal sequencing.

Parameters:
- DEPTH, 4: job FIFO entries. Power of 2, minimum 2.
- TAG_W, 4: width of the host job tag.
- TIMEOUT, 32: watchdog limit in cycles. Used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  host job valid.
- in_ready  out  1  FIFO can accept a job.
- in_central  in  16  {x1,y1,x2,y2}, one nibble each.
- in_radius  in  8  {r1,r2}.
- in_tag  in  TAG_W  job identifier.
- set_en  out  1  one-cycle launch pulse to SET.
- set_central  out  16  to SET central.
- set_radius  out  8  to SET radius.
- set_busy  in  1  SET busy.
- set_valid  in  1  SET idle / result ready.
- set_candidate  in  4  SET result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_candidate  out  4  captured count.
- out_tag  out  TAG_W  tag of the completed job.
- out_err  out  1  result produced by watchdog abort.
- done_cnt  out  16  completed results handed over; wraps at 2^16.

Behaviour:
- Reset, clk edge with rst=1:
  - FIFO empty, FSM in IDLE, job register zero.
  - set_en=0, set_central=0, set_radius=0.
  - out_valid=0, out_candidate=0, out_tag=0, out_err=0, done_cnt=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-job aborts the job silently (no result emitted) and discards all queued jobs. SET shares rst, so both blocks restart together.
- FIFO rules:
  - Push when in_valid & in_ready.
  - in_ready = !full. There is no same-cycle pass-through, and push while full is impossible.
  - Pop only in IDLE when not empty. Simultaneous push and pop is allowed in any non-full state.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
- set_central and set_radius are always driven from the job register. They stay stable from SETUP until the next job is loaded, which meets SET's requirement that inputs be held across its sampling window.
- FSM states:
  - IDLE: if FIFO not empty and out_valid=0, load job register from the FIFO head, pop, go to SETUP.
  - SETUP: set_en=0. If set_valid=1, go to LAUNCH; otherwise stay in SETUP.
  - LAUNCH: set_en=1 for exactly this cycle, go to WAIT_BUSY.
  - WAIT_BUSY: when set_busy=1, go to WAIT_DONE.
  - WAIT_DONE: when set_valid=1 and set_busy=0, capture set_candidate and the tag into the out registers, set out_err=0, go to RESULT.
  - RESULT: out_valid=1. On out_ready=1, clear out_valid, increment done_cnt, go to IDLE.
- out_valid stays high with stable data until accepted. A new job is never loaded while a result is pending (one result outstanding at most).
- Latency with SET:
  - push at cycle 0, pop at 1, SETUP at 2, set_en at 3 (L);
  - SET busy L+1..L+4, Cal L+5..L+6, set_valid back at L+7 (capture);
  - out_valid at cycle 11.
  - Back-to-back throughput: 11 cycles per job when out_ready is tied high.
- set_en is never asserted outside LAUNCH and never while set_valid=0.

Optional Feature:
- Macro: SET_DISPATCH_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT, go to RESULT with out_candidate=0, out_err=1, and the job's tag. The job is consumed.
  - Normal completion on the same cycle the limit is reached takes priority: out_err=0.
- Not defined: no counter, out_err is constant 0, and waiting is unbounded.

Test Plan:
- Single job (central=16'h2244, radius=8'h33, tag=5) with a behavioural SET returning candidate 7 → exactly one set_en pulse at cycle 3; set_central=16'h2244 held through capture; out_valid at cycle 11 with candidate 7, tag 5, err 0; done_cnt=1.
- Push 3 jobs on consecutive cycles (tags 1,2,3; model candidates 3,9,0), out_ready=1 → results returned in order 1/3, 2/9, 3/0, spaced 11 cycles apart; done_cnt=3.
- out_ready=0 while pushing 6 jobs with DEPTH=4 → in_ready drops after the FIFO holds 4; out_valid stays high with data stable; no second set_en until out_ready rises.
- Model holds set_valid=0 for 5 cycles before the first job → dispatcher waits in SETUP; set_en fires only after set_valid=1.
- rst pulsed at cycle 6 of a job with 2 more queued → all outputs return to reset values next cycle; no result emitted; in_ready=1; done_cnt=0.
- With SET_DISPATCH_WATCHDOG_EN and TIMEOUT=32, model never raises set_busy → result at LAUNCH+33 with candidate 0, err 1, correct tag; the next job then launches normally.

Source files
------------

// File: rtl/set_job_dispatcher.sv
// rtl/set_job_dispatcher.sv - job FIFO feeding the SET counter through its en/busy/valid handshake; optional watchdog: SET_DISPATCH_WATCHDOG_EN
module set_job_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_central,
  input  logic [7:0]       in_radius,
  input  logic [TAG_W-1:0] in_tag,
  output logic             set_en,
  output logic [15:0]      set_central,
  output logic [7:0]       set_radius,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [3:0]       set_candidate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_candidate,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [15:0]      done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int JW = 16 + 8 + TAG_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("set_job_dispatcher: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("set_job_dispatcher: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  // Job FIFO: one extra pointer bit separates full from empty.
  logic [JW-1:0]    r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [JW-1:0]    w_head;

  // Sequencer.
  state_t           r_state;
  state_t           w_state_next;
  logic             w_capture;
  logic             w_timeout;
  logic             w_accept;
  logic             w_wd_expire;

  // Job register driving SET; held until the next job is loaded.
  logic [15:0]      r_job_central;
  logic [7:0]       r_job_radius;
  logic [TAG_W-1:0] r_job_tag;

  // Result stream registers.
  logic             r_out_valid;
  logic [3:0]       r_out_candidate;
  logic [TAG_W-1:0] r_out_tag;
  logic [15:0]      r_done_cnt;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {in_tag, in_radius, in_central};
    end
  end

  // FIFO pointers; reset discards every queued job.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

`ifdef SET_DISPATCH_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wd_cnt;
  logic          r_out_err;

  // Watchdog: cleared while launching so it reads zero on entry to WAIT_BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_LAUNCH) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
      r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

  // Expiry fires on the cycle whose increment would reach TIMEOUT.
  assign w_wd_expire = (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) &&
                       (r_wd_cnt == CW'(TIMEOUT - 1));

  // Error flag tracks how the pending result was produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_err <= 1'b0;
    end else if (w_capture) begin
      r_out_err <= 1'b0;
    end else if (w_timeout) begin
      r_out_err <= 1'b1;
    end
  end

  assign out_err = r_out_err;
`else
  assign w_wd_expire = 1'b0;
  assign out_err     = 1'b0;
`endif

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sequencer next state and strobes; completion beats watchdog expiry.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_accept     = 1'b0;
    set_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !r_out_valid) begin
          w_pop        = 1'b1;
          w_state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (set_valid) begin
          w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        set_en       = 1'b1;
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (w_wd_expire) begin
          w_timeout    = 1'b1;
          w_state_next = S_RESULT;
        end else if (set_busy) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (set_valid && !set_busy) begin
          w_capture    = 1'b1;
          w_state_next = S_RESULT;
        end else if (w_wd_expire) begin
          w_timeout    = 1'b1;
          w_state_next = S_RESULT;
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          w_accept     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Job register loads from the FIFO head on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_job_central <= '0;
      r_job_radius  <= '0;
      r_job_tag     <= '0;
    end else if (w_pop) begin
      r_job_central <= w_head[15:0];
      r_job_radius  <= w_head[23:16];
      r_job_tag     <= w_head[JW-1:24];
    end
  end

  assign set_central = r_job_central;
  assign set_radius  = r_job_radius;

  // Result capture and hand-off; a timed-out job reports a zero count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid     <= 1'b0;
      r_out_candidate <= '0;
      r_out_tag       <= '0;
      r_done_cnt      <= '0;
    end else if (w_capture || w_timeout) begin
      r_out_valid     <= 1'b1;
      r_out_candidate <= w_timeout ? 4'd0 : set_candidate;
      r_out_tag       <= r_job_tag;
    end else if (w_accept) begin
      r_out_valid     <= 1'b0;
      r_done_cnt      <= r_done_cnt + 16'd1;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_candidate = r_out_candidate;
  assign out_tag       = r_out_tag;
  assign done_cnt      = r_done_cnt;

endmodule

// File: tb/tb_set_job_dispatcher.sv
// tb/tb_set_job_dispatcher.sv - scoreboard bench for set_job_dispatcher with a behavioural SET model
module tb_set_job_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_central;
  logic [7:0]       in_radius;
  logic [TAG_W-1:0] in_tag;
  logic             set_en;
  logic [15:0]      set_central;
  logic [7:0]       set_radius;
  logic             set_busy;
  logic             set_valid;
  logic [3:0]       set_candidate;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_candidate;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic [15:0]      done_cnt;

  always #5 clk = ~clk;

  set_job_dispatcher #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_central    (in_central),
    .in_radius     (in_radius),
    .in_tag        (in_tag),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_candidate (out_candidate),
    .out_tag       (out_tag),
    .out_err       (out_err),
    .done_cnt      (done_cnt)
  );

  typedef struct {
    logic [15:0]      central;
    logic [TAG_W-1:0] tag;
    logic [3:0]       cand;
    logic             err;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_cand_q[$];
  int         rise_q[$];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int en_count = 0;
  int last_en_cyc = 0;
  int last_push_cyc = 0;
  int n_results = 0;
  logic prev_ov = 1'b0;
  logic bg_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural SET: busy 4 cycles after en, 2 Cal cycles, then valid with the result.
  logic       m_valid_r;
  logic       m_hold = 1'b0;
  logic       m_nobusy = 1'b0;
  int         m_cnt;
  logic [3:0] m_res;

  assign set_valid = m_valid_r & ~m_hold;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt         <= 0;
      m_valid_r     <= 1'b1;
      set_busy      <= 1'b0;
      set_candidate <= 4'd0;
      m_res         <= 4'd0;
    end else if (m_cnt == 0) begin
      if (set_en && set_valid && !m_nobusy) begin
        m_cnt     <= 1;
        set_busy  <= 1'b1;
        m_valid_r <= 1'b0;
        if (m_cand_q.size() > 0) m_res <= m_cand_q.pop_front();
        else m_res <= 4'd0;
      end
    end else if (m_cnt == 6) begin
      m_cnt         <= 0;
      m_valid_r     <= 1'b1;
      set_candidate <= m_res;
    end else begin
      m_cnt    <= m_cnt + 1;
      set_busy <= (m_cnt < 4);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: launch rules and scoreboard comparison of every presented result.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (set_en) begin
        en_count++;
        last_en_cyc = cyc;
        check("en_with_valid", set_valid, 1'b1);
        check("en_no_pending", out_valid, 1'b0);
        if (exp_q.size() > 0) check("en_central", set_central, exp_q[0].central);
      end
      if (out_valid) begin
        if (!prev_ov) rise_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_result", exp_q.size(), 1);
        end else begin
          check("out_candidate", out_candidate, exp_q[0].cand);
          check("out_tag", out_tag, exp_q[0].tag);
          check("out_err", out_err, exp_q[0].err);
          check("held_central", set_central, exp_q[0].central);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_results++;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic push_job(input logic [15:0] c, input logic [7:0] r,
                          input logic [TAG_W-1:0] t, input logic [3:0] cand,
                          input logic err);
    int g;
    exp_t e;
    g = 0;
    in_valid   = 1'b1;
    in_central = c;
    in_radius  = r;
    in_tag     = t;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("push_timeout", in_ready, 1'b1);
    e.central = c;
    e.tag     = t;
    e.cand    = err ? 4'd0 : cand;
    e.err     = err;
    exp_q.push_back(e);
    if (!err) m_cand_q.push_back(cand);
    last_push_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget);
    int g = 0;
    while (n_results < target && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (n_results < target) check("result_timeout", n_results, target);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_set_en", set_en, 1'b0);
    check("rst_set_central", set_central, 16'h0);
    check("rst_set_radius", set_radius, 8'h0);
    check("rst_out_candidate", out_candidate, 4'h0);
    check("rst_out_tag", out_tag, 4'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_done_cnt", done_cnt, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 20000);
    $fatal(1, "bench time limit");
  end

  initial begin
    int p0, e0, r0, n0, rel_cyc, g;
    int done_exp;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_central = '0;
    in_radius  = '0;
    in_tag     = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;

    // Single job: launch at +3, result at +11.
    e0 = en_count; r0 = rise_q.size(); n0 = n_results;
    push_job(16'h2244, 8'h33, 4'd5, 4'd7, 1'b0);
    p0 = last_push_cyc;
    wait_results(n0 + 1, 100);
    check("t1_en_count", en_count - e0, 1);
    check("t1_en_cycle", last_en_cyc - p0, 3);
    if (rise_q.size() > r0) check("t1_ov_cycle", rise_q[r0] - p0, 11);
    else check("t1_ov_seen", rise_q.size(), r0 + 1);
    check("t1_done_cnt", done_cnt, 16'd1);

    // Three consecutive jobs: in order, 11 cycles apart.
    r0 = rise_q.size(); n0 = n_results;
    push_job(16'h1357, 8'h21, 4'd1, 4'd3, 1'b0);
    push_job(16'h2468, 8'h12, 4'd2, 4'd9, 1'b0);
    push_job(16'hA0B1, 8'h45, 4'd3, 4'd0, 1'b0);
    wait_results(n0 + 3, 200);
    if (rise_q.size() >= r0 + 3) begin
      check("t2_spacing_a", rise_q[r0 + 1] - rise_q[r0], 11);
      check("t2_spacing_b", rise_q[r0 + 2] - rise_q[r0 + 1], 11);
    end else begin
      check("t2_ov_seen", rise_q.size(), r0 + 3);
    end
    check("t2_done_cnt", done_cnt, 16'd4);

    // Back-pressure: six jobs with the consumer stalled.
    out_ready = 1'b0;
    e0 = en_count; n0 = n_results;
    bg_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push_job(16'h3000 + 16'(i * 17), 8'(8'h50 + i), 4'(6 + i), 4'(i * 3 + 1), 1'b0);
        end
        bg_done = 1'b1;
      end
    join_none
    repeat (30) @(negedge clk);
    check("t3_in_ready_low", in_ready, 1'b0);
    check("t3_single_launch", en_count - e0, 1);
    check("t3_out_valid_held", out_valid, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_results(n0 + 6, 200);
    g = 0;
    while (!bg_done && g < 50) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("t3_bg_done", bg_done, 1'b1);
    check("t3_launches", en_count - e0, 6);
    check("t3_done_cnt", done_cnt, 16'd10);

    // SET not ready: dispatcher must wait in SETUP.
    m_hold = 1'b1;
    e0 = en_count; n0 = n_results;
    push_job(16'h7788, 8'h99, 4'd12, 4'd5, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_en_during_hold", en_count - e0, 0);
    m_hold = 1'b0;
    @(negedge clk);
    rel_cyc = cyc;
    wait_results(n0 + 1, 100);
    check("t4_en_after_release", last_en_cyc - rel_cyc, 1);
    check("t4_done_cnt", done_cnt, 16'd11);

    // Reset mid-job with two queued behind it.
    push_job(16'h1111, 8'h11, 4'd13, 4'd1, 1'b0);
    p0 = last_push_cyc;
    push_job(16'h2222, 8'h22, 4'd14, 4'd2, 1'b0);
    push_job(16'h3333, 8'h33, 4'd15, 4'd3, 1'b0);
    while (cyc < p0 + 6) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_cand_q.delete();
    e0 = en_count; n0 = n_results;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();
    repeat (30) @(negedge clk);
    check("t5_no_relaunch", en_count - e0, 0);
    check("t5_no_result", n_results - n0, 0);
    check("t5_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    done_exp = 0;

`ifdef SET_DISPATCH_WATCHDOG_EN
    // SET never goes busy: watchdog returns an error result at LAUNCH+33.
    m_nobusy = 1'b1;
    r0 = rise_q.size(); n0 = n_results;
    push_job(16'h5A5A, 8'h42, 4'd9, 4'd0, 1'b1);
    wait_results(n0 + 1, 100);
    if (rise_q.size() > r0) check("t6_wd_latency", rise_q[r0] - last_en_cyc, 33);
    else check("t6_ov_seen", rise_q.size(), r0 + 1);
    m_nobusy = 1'b0;
    done_exp = done_exp + 1;
`endif

    // Normal job after reset (and after an abort, when enabled).
    n0 = n_results;
    push_job(16'hC3D4, 8'h67, 4'd4, 4'd11, 1'b0);
    p0 = last_push_cyc;
    wait_results(n0 + 1, 100);
    done_exp = done_exp + 1;
    check("t7_en_cycle", last_en_cyc - p0, 3);
    check("t7_done_cnt", done_cnt, 16'(done_exp));
    check("t7_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
